// File: rtl/tournament_select.sv
// Binary tournament selector: samples two PRNG candidate indices, reads both fitness
// words from the synchronous population RAM, and hands the winner downstream via valid/ready.
module tournament_select #(
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned FIT_W    = 16,
  parameter int unsigned POP_SIZE = 32,
  parameter int unsigned MINIMIZE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] random0,
  input  logic [IDX_W-1:0] random1,
  input  logic             start,
  output logic             busy,
  output logic [IDX_W-1:0] fit_addr,
  input  logic [FIT_W-1:0] fit_data,
  output logic [IDX_W-1:0] parent_idx,
  output logic [FIT_W-1:0] parent_fit,
  output logic             parent_valid,
  input  logic             parent_ready
);

  localparam int unsigned WIDE_W = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CMP, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] cand_a;
  logic [IDX_W-1:0] cand_b;
  logic [FIT_W-1:0] fit_a;
  logic             b_wins;

  // Fold an out-of-range PRNG index back into the population.
  function automatic logic [IDX_W-1:0] fold(input logic [IDX_W-1:0] idx);
    logic [WIDE_W-1:0] wide;
    wide = {1'b0, idx};
    if (wide >= WIDE_W'(POP_SIZE)) fold = IDX_W'(wide - WIDE_W'(POP_SIZE));
    else                           fold = idx;
  endfunction

  // In CMP fit_data carries B's fitness; ties and identical candidates go to A.
  always_comb begin
    b_wins = 1'b0;
    if (cand_a != cand_b) begin
      if (MINIMIZE != 0) b_wins = (fit_data < fit_a);
      else               b_wins = (fit_data > fit_a);
    end
  end

  // fit_addr is registered so that it shows cand_a only during RD_A and cand_b otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cand_a       <= '0;
      cand_b       <= '0;
      fit_a        <= '0;
      fit_addr     <= '0;
      parent_idx   <= '0;
      parent_fit   <= '0;
      parent_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cand_a   <= fold(random0);
            cand_b   <= fold(random1);
            fit_addr <= fold(random0);
            busy     <= 1'b1;
            state    <= RD_A;
          end
        end
        RD_A: begin
          fit_addr <= cand_b;
          state    <= RD_B;
        end
        RD_B: begin
          fit_a <= fit_data;
          state <= CMP;
        end
        CMP: begin
          parent_idx   <= b_wins ? cand_b : cand_a;
          parent_fit   <= b_wins ? fit_data : fit_a;
          parent_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (parent_ready) begin
            parent_valid <= 1'b0;
            if (start) begin
              cand_a   <= fold(random0);
              cand_b   <= fold(random1);
              fit_addr <= fold(random0);
              state    <= RD_A;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tournament_select.sv
// Directed bench for tournament_select: three instances (maximise, minimise, POP_SIZE=20)
// share stimulus and a fitness table, each with its own synchronous read port.
module tb_tournament_select;

  localparam int unsigned IDX_W = 5;
  localparam int unsigned FIT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IDX_W-1:0] random0;
  logic [IDX_W-1:0] random1;
  logic             start;
  logic             parent_ready;

  logic [FIT_W-1:0] mem [32];

  logic             busy0, busy1, busy2;
  logic [IDX_W-1:0] fa0, fa1, fa2;
  logic [FIT_W-1:0] fd0, fd1, fd2;
  logic [IDX_W-1:0] pidx0, pidx1, pidx2;
  logic [FIT_W-1:0] pfit0, pfit1, pfit2;
  logic             pv0, pv1, pv2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Synchronous-read fitness RAM ports
  always @(posedge clk) begin
    fd0 <= mem[fa0];
    fd1 <= mem[fa1];
    fd2 <= mem[fa2];
  end

  tournament_select #(.IDX_W(IDX_W), .FIT_W(FIT_W), .POP_SIZE(32), .MINIMIZE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .random0(random0), .random1(random1), .start(start),
    .busy(busy0), .fit_addr(fa0), .fit_data(fd0), .parent_idx(pidx0), .parent_fit(pfit0),
    .parent_valid(pv0), .parent_ready(parent_ready));

  tournament_select #(.IDX_W(IDX_W), .FIT_W(FIT_W), .POP_SIZE(32), .MINIMIZE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .random0(random0), .random1(random1), .start(start),
    .busy(busy1), .fit_addr(fa1), .fit_data(fd1), .parent_idx(pidx1), .parent_fit(pfit1),
    .parent_valid(pv1), .parent_ready(parent_ready));

  tournament_select #(.IDX_W(IDX_W), .FIT_W(FIT_W), .POP_SIZE(20), .MINIMIZE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .random0(random0), .random1(random1), .start(start),
    .busy(busy2), .fit_addr(fa2), .fit_data(fd2), .parent_idx(pidx2), .parent_fit(pfit2),
    .parent_valid(pv2), .parent_ready(parent_ready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge and advance to just after the edge where the parent appears.
  task automatic run_tour(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
    random0 = a;
    random1 = b;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
  endtask

  logic [IDX_W-1:0] pa [4];
  logic [IDX_W-1:0] pb [4];
  logic [IDX_W-1:0] wi [4];
  logic [FIT_W-1:0] wf [4];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'(i);
    mem[3] = 16'd100;  mem[9] = 16'd250;
    mem[4] = 16'd77;   mem[20] = 16'd77;
    mem[7] = 16'd5;
    mem[5] = 16'd60;   mem[11] = 16'd40;
    rst_n = 1'b0; start = 1'b1; parent_ready = 1'b0;
    random0 = 5'd17; random1 = 5'd23;

    // Reset held with start asserted
    tick(); tick(); tick();
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_valid", 32'(pv0), 32'd0);
    chk("rst_idx", 32'(pidx0), 32'd0);
    chk("rst_addr", 32'(fa0), 32'd0);
    chk("rst_fit", 32'(pfit0), 32'd0);
    rst_n = 1'b1; start = 1'b0; parent_ready = 1'b1;
    tick();
    chk("idle_busy", 32'(busy0), 32'd0);

    // Basic tournament with read-address sequence and latency
    random0 = 5'd3; random1 = 5'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rda_busy", 32'(busy0), 32'd1);
    chk("rda_addr", 32'(fa0), 32'd3);
    tick();
    chk("rdb_addr", 32'(fa0), 32'd9);
    tick();
    chk("cmp_valid", 32'(pv0), 32'd0);
    tick();
    chk("max_valid", 32'(pv0), 32'd1);
    chk("max_idx", 32'(pidx0), 32'd9);
    chk("max_fit", 32'(pfit0), 32'd250);
    chk("min_idx", 32'(pidx1), 32'd3);
    chk("min_fit", 32'(pfit1), 32'd100);
    tick();
    chk("done_valid", 32'(pv0), 32'd0);
    chk("done_busy", 32'(busy0), 32'd0);

    // Ties go to candidate A
    run_tour(5'd20, 5'd4);
    chk("tie_idx", 32'(pidx0), 32'd20);
    chk("tie_fit", 32'(pfit0), 32'd77);
    chk("tie_min_idx", 32'(pidx1), 32'd20);
    tick();
    run_tour(5'd7, 5'd7);
    chk("same_idx", 32'(pidx0), 32'd7);
    chk("same_fit", 32'(pfit0), 32'd5);
    tick();

    // Backpressure: outputs frozen while inputs and RAM move
    parent_ready = 1'b0;
    run_tour(5'd3, 5'd9);
    chk("bp_valid0", 32'(pv0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      random0 = 5'(i + 1);
      random1 = 5'(i + 12);
      start   = 1'(i % 2);
      mem[9]  = 16'(1000 + i);
      tick();
      chk("bp_valid", 32'(pv0), 32'd1);
      chk("bp_idx", 32'(pidx0), 32'd9);
      chk("bp_fit", 32'(pfit0), 32'd250);
      chk("bp_busy", 32'(busy0), 32'd1);
    end
    mem[9] = 16'd250;
    start = 1'b0; parent_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(pv0), 32'd0);
    chk("bp_release_busy", 32'(busy0), 32'd0);
    tick();
    chk("bp_idle_valid", 32'(pv0), 32'd0);

    // Back-to-back: one parent every 4 cycles, fresh indices each time
    pa[0] = 5'd3; pb[0] = 5'd9; wi[0] = 5'd9; wf[0] = 16'd250;
    pa[1] = 5'd7; pb[1] = 5'd3; wi[1] = 5'd3; wf[1] = 16'd100;
    pa[2] = 5'd9; pb[2] = 5'd4; wi[2] = 5'd9; wf[2] = 16'd250;
    pa[3] = 5'd4; pb[3] = 5'd7; wi[3] = 5'd4; wf[3] = 16'd77;
    random0 = pa[0]; random1 = pb[0]; start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        random0 = pa[k+1];
        random1 = pb[k+1];
      end else begin
        start = 1'b0;
      end
      tick(); tick(); tick();
      chk("b2b_valid", 32'(pv0), 32'd1);
      chk("b2b_idx", 32'(pidx0), 32'(wi[k]));
      chk("b2b_fit", 32'(pfit0), 32'(wf[k]));
      tick();
      chk("b2b_gap_valid", 32'(pv0), 32'd0);
      chk("b2b_busy", 32'(busy0), (k < 3) ? 32'd1 : 32'd0);
    end

    // Index fold with POP_SIZE=20
    run_tour(5'd25, 5'd31);
    chk("fold_idx", 32'(pidx2), 32'd5);
    chk("fold_fit", 32'(pfit2), 32'd60);
    tick();
    random0 = 5'd25; random1 = 5'd31; start = 1'b1;
    tick();
    start = 1'b0;
    chk("fold_addr_a", 32'(fa2), 32'd5);
    tick();
    chk("fold_addr_b", 32'(fa2), 32'd11);
    tick();
    chk("cmp_busy", 32'(busy2), 32'd1);
    // Reset lands on the CMP edge: the tournament is dropped
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_valid", 32'(pv2), 32'd0);
    chk("abort_busy", 32'(busy2), 32'd0);
    chk("abort_addr", 32'(fa2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_quiet", 32'(pv2), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
